// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder: memory-mapped SECDED decoder for (16,11) extended-Hamming words
// Ports: clock/reset_n (sync, active low); req/ack handshake (ack is a level held until next accepted req);
// mem_addr/mem_rd_data (combinational read), mem_wr_en/mem_wr_data (byte write at the edge);
// err1_count/err2_count report corrected single and detected double errors of the last run.
module hamming_secded_decoder #(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int ADDR_W    = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req,
    output logic              ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic [3:0]        err1_count,
    output logic [3:0]        err2_count
);
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE} state_t;
    localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [7:0]        lo_q, lo_d, hi_q, hi_d;
    logic [10:0]       data_q, data_d;
    logic [1:0]        flag_q, flag_d;
    logic [3:0]        err1_q, err1_d, err2_q, err2_d;
    logic              ack_q, ack_d;
    logic [15:0]       w, wc;
    logic [3:0]        syn;
    logic              par;
    logic [ADDR_W-1:0] off;
    // The syndrome is the XOR of the positions holding a one; a nonzero overall parity
    // means an odd number of flips, so the syndrome then names the flipped bit (0 = p0).
    always_comb begin
        w   = {hi_q, lo_q};
        syn = '0;
        for (int k = 1; k < 16; k++)
            syn = w[k] ? syn ^ 4'(k) : syn;
        par = ^w;
        wc  = par ? w ^ (16'd1 << syn) : w;
    end
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        data_d      = data_q;
        flag_d      = flag_q;
        err1_d      = err1_q;
        err2_d      = err2_q;
        ack_d       = ack_q;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        off         = ADDR_W'(idx_q) << 1;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    ack_d   = 1'b0;
                    err1_d  = '0;
                    err2_d  = '0;
                    idx_d   = '0;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                mem_addr = ADDR_W'(SRC_BASE) + off;
                lo_d     = mem_rd_data;
                state_d  = RD_HI;
            end
            RD_HI: begin
                mem_addr = ADDR_W'(SRC_BASE) + off + ADDR_W'(1);
                hi_d     = mem_rd_data;
                state_d  = DECODE;
            end
            DECODE: begin
                data_d  = {wc[15:9], wc[7:5], wc[3]};
                flag_d  = par ? 2'b01 : (syn != 4'd0 ? 2'b10 : 2'b00);
                err1_d  = (par && err1_q != 4'hF) ? err1_q + 4'd1 : err1_q;
                err2_d  = (!par && syn != 4'd0 && err2_q != 4'hF) ? err2_q + 4'd1 : err2_q;
                state_d = WR_LO;
            end
            WR_LO: begin
                mem_addr    = ADDR_W'(DST_BASE) + off;
                mem_wr_en   = 1'b1;
                mem_wr_data = data_q[7:0];
                state_d     = WR_HI;
            end
            WR_HI: begin
                mem_addr    = ADDR_W'(DST_BASE) + off + ADDR_W'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = {flag_q, 3'b000, data_q[10:8]};
                idx_d       = idx_q + IW'(1);
                state_d     = (idx_q == IW'(NUM_WORDS - 1)) ? DONE : RD_LO;
            end
            DONE: begin
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            flag_q  <= '0;
            err1_q  <= '0;
            err2_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            err1_q  <= err1_d;
            err2_q  <= err2_d;
            ack_q   <= ack_d;
        end
    end
    assign ack        = ack_q;
    assign err1_count = err1_q;
    assign err2_count = err2_q;
endmodule

// File: tb/tb_hamming_secded_decoder.sv
// tb_hamming_secded_decoder: randomized and directed checks of the SECDED decoder against a nearest-codeword model
module tb_hamming_secded_decoder;
    localparam int N = 15, SRC = 30, DST = 0;
    logic       clock = 1'b0, reset_n = 1'b0, req = 1'b0;
    logic       ack, mem_wr_en;
    logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
    logic [3:0] err1_count, err2_count;
    logic [7:0]  img    [256];
    logic [7:0]  wr_mem [256];
    logic [15:0] cw     [2048];
    logic [15:0] src_w  [N];
    logic [7:0]  exp_lo [N];
    logic [7:0]  exp_hi [N];
    logic [15:0] exp_q  [$];
    int n_cmp = 0, n_fail = 0, exp_e1, exp_e2;

    always #5 clock = ~clock;

    hamming_secded_decoder dut (
        .clock(clock), .reset_n(reset_n), .req(req), .ack(ack),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .err1_count(err1_count), .err2_count(err2_count)
    );

    assign mem_rd_data = img[mem_addr];
    always @(posedge clock) if (mem_wr_en) wr_mem[mem_addr] <= mem_wr_data;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the next byte the model predicts, in order.
    always @(negedge clock) begin
        if (reset_n && mem_wr_en) begin
            if (exp_q.size() == 0) check("unexpected_write", {mem_addr, mem_wr_data}, 0);
            else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e[15:8]);
                check("wr_data", mem_wr_data, e[7:0]);
            end
        end
    end

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        int j;
        w = '0;
        j = 0;
        for (int k = 3; k < 16; k++)
            if ((k & (k - 1)) != 0) begin
                w[k] = d[j];
                j++;
            end
        for (int b = 0; b < 4; b++) begin
            int p;
            logic x;
            p = 1 << b;
            x = 1'b0;
            for (int k = 1; k < 16; k++)
                if ((k & p) != 0 && k != p) x ^= w[k];
            w[p] = x;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic void decode_ref(input logic [15:0] r, output logic [10:0] d, output logic [1:0] f);
        int best, bv;
        best = 99;
        bv = 0;
        for (int v = 0; v < 2048; v++) begin
            int c;
            c = $countones(r ^ cw[v]);
            if (c < best) begin
                best = c;
                bv = v;
            end
        end
        d = best < 2 ? 11'(bv) : {r[15:9], r[7:5], r[3]};
        f = best == 0 ? 2'd0 : (best == 1 ? 2'd1 : 2'd2);
    endfunction

    task automatic load();
        logic [10:0] d;
        logic [1:0] f;
        exp_q.delete();
        exp_e1 = 0;
        exp_e2 = 0;
        for (int i = 0; i < N; i++) begin
            img[SRC + 2 * i]     = src_w[i][7:0];
            img[SRC + 2 * i + 1] = src_w[i][15:8];
            decode_ref(src_w[i], d, f);
            exp_lo[i] = d[7:0];
            exp_hi[i] = {f, 3'b000, d[10:8]};
            exp_q.push_back({8'(DST + 2 * i), exp_lo[i]});
            exp_q.push_back({8'(DST + 2 * i + 1), exp_hi[i]});
            if (f == 2'd1) exp_e1++;
            if (f == 2'd2) exp_e2++;
        end
    endtask

    task automatic run(input int reset_at, input int pulse_at);
        int n;
        n = 0;
        @(negedge clock);
        req = 1'b1;
        while (n < 200) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 1) begin
                check("ack_cleared", ack, 0);
                req = 1'b0;
            end
            if (n == pulse_at) req = 1'b1;
            if (n == pulse_at + 1) req = 1'b0;
            if (n == reset_at) begin
                reset_n = 1'b0;
                @(posedge clock);
                #1;
                check("rst_ack", ack, 0);
                check("rst_wr_en", mem_wr_en, 0);
                check("rst_addr", mem_addr, 0);
                check("rst_wr_data", mem_wr_data, 0);
                check("rst_err1", err1_count, 0);
                check("rst_err2", err2_count, 0);
                exp_q.delete();
                reset_n = 1'b1;
                repeat (3) begin
                    @(posedge clock);
                    #1;
                    check("post_rst_ack", ack, 0);
                    check("post_rst_wr_en", mem_wr_en, 0);
                end
                return;
            end
            if (ack) break;
        end
        check("ack_latency", n, 77);
        check("writes_left", exp_q.size(), 0);
        check("err1", err1_count, exp_e1);
        check("err2", err2_count, exp_e2);
        for (int i = 0; i < N; i++) begin
            check("dst_lo", wr_mem[DST + 2 * i], exp_lo[i]);
            check("dst_hi", wr_mem[DST + 2 * i + 1], exp_hi[i]);
        end
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check("ack_held", ack, 1);
        check("err1_held", err1_count, exp_e1);
    endtask

    initial begin
        logic [10:0] d;
        logic [1:0] f;
        int inj1, inj2;
        int rd [N];
        int rn [N];
        for (int v = 0; v < 2048; v++) cw[v] = encode(11'(v));
        for (int a = 0; a < 256; a++) img[a] = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("reset_ack", ack, 0);
        check("reset_wr_en", mem_wr_en, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_err1", err1_count, 0);
        @(negedge clock);
        reset_n = 1'b1;

        check("enc_ones", encode(11'h7FF), 16'hFFFF);
        check("enc_zero", encode(11'h000), 16'h0000);
        decode_ref(16'h0020, d, f);
        check("model_single", {f, 5'b0, d}, {2'd1, 5'b0, 11'h000});
        decode_ref(16'h0028, d, f);
        check("model_double", {f, 5'b0, d}, {2'd2, 5'b0, 11'h003});

        for (int i = 0; i < N; i++) src_w[i] = 16'hFFFF;
        load();
        run(0, 0);
        for (int i = 0; i < N; i++) begin
            check("ones_lo", wr_mem[DST + 2 * i], 8'hFF);
            check("ones_hi", wr_mem[DST + 2 * i + 1], 8'h07);
        end
        check("ones_err1", err1_count, 0);
        check("ones_err2", err2_count, 0);

        for (int i = 0; i < N; i++) src_w[i] = 16'h0000;
        src_w[0] = 16'h0020;
        load();
        run(0, 0);
        check("single_lo", wr_mem[0], 8'h00);
        check("single_hi", wr_mem[1], 8'h40);
        check("single_err1", err1_count, 1);

        src_w[0] = 16'h0028;
        load();
        run(0, 0);
        check("double_lo", wr_mem[0], 8'h03);
        check("double_hi", wr_mem[1], 8'h80);
        check("double_err1", err1_count, 0);
        check("double_err2", err2_count, 1);

        src_w[0] = 16'hFFFE;
        load();
        run(0, 0);
        check("p0_lo", wr_mem[0], 8'hFF);
        check("p0_hi", wr_mem[1], 8'h47);
        check("p0_err1", err1_count, 1);

        for (int it = 0; it < 4; it++) begin
            inj1 = 0;
            inj2 = 0;
            for (int i = 0; i < N; i++) begin
                int p1, p2;
                logic [15:0] w;
                rd[i] = int'($urandom_range(0, 2047));
                rn[i] = int'($urandom_range(0, 2));
                p1 = int'($urandom_range(0, 15));
                p2 = (p1 + int'($urandom_range(1, 15))) % 16;
                w = encode(11'(rd[i]));
                if (rn[i] >= 1) w[p1] = ~w[p1];
                if (rn[i] == 2) w[p2] = ~w[p2];
                src_w[i] = w;
                if (rn[i] == 1) inj1++;
                if (rn[i] == 2) inj2++;
            end
            load();
            run(0, 0);
            check("rand_err1", err1_count, inj1);
            check("rand_err2", err2_count, inj2);
            for (int i = 0; i < N; i++) begin
                check("rand_flag", wr_mem[DST + 2 * i + 1][7:6], rn[i]);
                if (rn[i] < 2)
                    check("rand_payload", {wr_mem[DST + 2 * i + 1][2:0], wr_mem[DST + 2 * i]}, rd[i]);
            end
        end

        for (int i = 0; i < N; i++) src_w[i] = encode(11'($urandom_range(0, 2047))) ^ (16'd1 << (i % 16));
        load();
        run(36, 0);
        load();
        run(0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
